jump_base_responder: RTL and testbench

//  Register-file-side responder for register-based jumps (opcode 4'b1111, bit0=1). Accepts one base-register

---
 rtl/jump_base_responder.sv | 117 +++++++++++
 tb/tb_jump_base_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/jump_base_responder.sv
// Register-file-side responder for register-based jumps: waits until the base register is not busy, then returns its value.
// Optional macro JB_WB_BYPASS_EN takes the base straight from a matching writeback while the register is still busy.
module jump_base_responder #(
  parameter  int unsigned DATA_W     = 16,
  parameter  int unsigned NUM_REGS   = 16,
  parameter  int unsigned WAIT_CNT_W = 8,
  localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  has_mispredict,
  input  logic                  jmp_req_valid,
  input  logic [IDX_W-1:0]      jmp_req_rs,
  output logic                  jmp_req_ready,
  output logic [IDX_W-1:0]      rf_rd_addr,
  input  logic [DATA_W-1:0]     rf_rd_data,
  input  logic [NUM_REGS-1:0]   reg_busy,
  input  logic                  wb_valid,
  input  logic [IDX_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     jump_base_from_rf_0,
  output logic                  jump_base_rdy_from_rf_0,
  output logic [WAIT_CNT_W-1:0] last_wait_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rs_q, rs_d;
  logic [DATA_W-1:0]     base_q, base_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_CNT_W-1:0] last_wait_q, last_wait_d;

  logic busy_hit;
  logic bypass_hit;

  // Register 0 is hard-wired to zero and therefore never busy.
  assign busy_hit = reg_busy[rs_q] && (rs_q != '0);

`ifdef JB_WB_BYPASS_EN
  assign bypass_hit = busy_hit && wb_valid && (wb_addr == rs_q);
`else
  logic unused_wb;
  assign unused_wb  = ^{wb_valid, wb_addr, wb_data};
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    base_d      = base_q;
    wait_cnt_d  = wait_cnt_q;
    last_wait_d = last_wait_q;

    case (state_q)
      ST_IDLE: begin
        if (jmp_req_valid) begin
          rs_d       = jmp_req_rs;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bypass_hit) begin
          base_d  = wb_data;
          state_d = ST_RESP;
        end else if (!busy_hit) begin
          base_d  = (rs_q == '0) ? '0 : rf_rd_data;
          state_d = ST_RESP;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        last_wait_d = wait_cnt_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything: drop any pending or newly presented request.
    if (has_mispredict) begin
      state_d     = ST_IDLE;
      rs_d        = rs_q;
      base_d      = base_q;
      wait_cnt_d  = '0;
      last_wait_d = last_wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rs_q        <= '0;
      base_q      <= '0;
      wait_cnt_q  <= '0;
      last_wait_q <= '0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      base_q      <= base_d;
      wait_cnt_q  <= wait_cnt_d;
      last_wait_q <= last_wait_d;
    end
  end

  assign jmp_req_ready           = (state_q == ST_IDLE);
  assign jump_base_rdy_from_rf_0 = (state_q == ST_RESP) && !has_mispredict;
  assign jump_base_from_rf_0     = base_q;
  assign rf_rd_addr              = rs_q;
  assign last_wait_cycles        = last_wait_q;

endmodule

// File: tb/tb_jump_base_responder.sv
// Directed self-checking bench for jump_base_responder; expectations follow JB_WB_BYPASS_EN when defined.
module tb_jump_base_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        has_mispredict;
  logic        jmp_req_valid;
  logic [3:0]  jmp_req_rs;
  logic        jmp_req_ready;
  logic [3:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic [15:0] reg_busy;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] jump_base_from_rf_0;
  logic        jump_base_rdy_from_rf_0;
  logic [7:0]  last_wait_cycles;

  logic [15:0] rf [16];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_rd_addr];

  jump_base_responder #(.DATA_W(16), .NUM_REGS(16), .WAIT_CNT_W(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .has_mispredict          (has_mispredict),
    .jmp_req_valid           (jmp_req_valid),
    .jmp_req_rs              (jmp_req_rs),
    .jmp_req_ready           (jmp_req_ready),
    .rf_rd_addr              (rf_rd_addr),
    .rf_rd_data              (rf_rd_data),
    .reg_busy                (reg_busy),
    .wb_valid                (wb_valid),
    .wb_addr                 (wb_addr),
    .wb_data                 (wb_data),
    .jump_base_from_rf_0     (jump_base_from_rf_0),
    .jump_base_rdy_from_rf_0 (jump_base_rdy_from_rf_0),
    .last_wait_cycles        (last_wait_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request now; the register stays busy (busy_mask) for the first busy_cycles WAIT cycles.
  task automatic run_req(input logic [3:0] rs, input int busy_cycles, input logic [15:0] busy_mask,
                         input bit wb_en, input logic [15:0] wb_d,
                         output int lat, output logic [15:0] base_o);
    lat    = -1;
    base_o = 'x;
    jmp_req_valid = 1'b1;
    jmp_req_rs    = rs;
    reg_busy      = (busy_cycles > 0) ? busy_mask : 16'h0;
    for (int k = 1; k <= 400; k++) begin
      cyc();
      jmp_req_valid = 1'b0;
      reg_busy      = (k <= busy_cycles) ? busy_mask : 16'h0;
      wb_valid      = wb_en && (k == 1);
      wb_addr       = rs;
      wb_data       = wb_d;
      #1;
      if (jump_base_rdy_from_rf_0) begin
        lat    = k;
        base_o = jump_base_from_rf_0;
        break;
      end
    end
    wb_valid = 1'b0;
    reg_busy = 16'h0;
  endtask

  task automatic after_resp(input string tag, input logic [7:0] exp_last);
    cyc();
    #1;
    check_eq({tag, "_rdy_drop"}, {31'b0, jump_base_rdy_from_rf_0}, 32'd0);
    check_eq({tag, "_ready"}, {31'b0, jmp_req_ready}, 32'd1);
    check_eq({tag, "_last_wait"}, {24'b0, last_wait_cycles}, {24'b0, exp_last});
  endtask

  int          lat;
  logic [15:0] base;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    rf[0] = 16'hDEAD;  // never observable: register 0 reads as zero
    rf[2] = 16'h2222;
    rf[3] = 16'h0040;
    rf[5] = 16'h1234;
    rf[7] = 16'h7777;
    rst = 1'b1; has_mispredict = 1'b0; jmp_req_valid = 1'b1; jmp_req_rs = 4'd3;
    reg_busy = 16'h0; wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 16'h0;

    // Reset with a request held high.
    for (int c = 0; c < 2; c++) begin
      cyc();
      check_eq("rst_rdy", {31'b0, jump_base_rdy_from_rf_0}, 32'd0);
      check_eq("rst_ready", {31'b0, jmp_req_ready}, 32'd1);
      check_eq("rst_base", {16'b0, jump_base_from_rf_0}, 32'd0);
      check_eq("rst_last", {24'b0, last_wait_cycles}, 32'd0);
    end
    rst = 1'b0; jmp_req_valid = 1'b0;
    cyc();

    // Not busy: rdy at N+2.
    run_req(4'd3, 0, 16'h0, 1'b0, 16'h0, lat, base);
    check_eq("nb_lat", 32'(lat), 32'd2);
    check_eq("nb_base", {16'b0, base}, 32'h0040);
    after_resp("nb", 8'd0);

    // Busy four cycles.
    run_req(4'd5, 4, 16'h0020, 1'b0, 16'h0, lat, base);
    check_eq("busy_lat", 32'(lat), 32'd6);
    check_eq("busy_base", {16'b0, base}, 32'h1234);
    after_resp("busy", 8'd4);

    // Writeback to the busy register during WAIT.
    run_req(4'd5, 4, 16'h0020, 1'b1, 16'hBEEF, lat, base);
`ifdef JB_WB_BYPASS_EN
    check_eq("byp_lat", 32'(lat), 32'd2);
    check_eq("byp_base", {16'b0, base}, 32'hBEEF);
    after_resp("byp", 8'd0);
`else
    check_eq("byp_lat", 32'(lat), 32'd6);
    check_eq("byp_base", {16'b0, base}, 32'h1234);
    after_resp("byp", 8'd4);
`endif

    // Flush in WAIT.
    jmp_req_valid = 1'b1; jmp_req_rs = 4'd5; reg_busy = 16'h0020;
    cyc();
    jmp_req_valid = 1'b0;
    cyc();
    has_mispredict = 1'b1;
    #1;
    check_eq("fw_rdy", {31'b0, jump_base_rdy_from_rf_0}, 32'd0);
    cyc();
    has_mispredict = 1'b0; reg_busy = 16'h0;
    #1;
    check_eq("fw_ready", {31'b0, jmp_req_ready}, 32'd1);
    check_eq("fw_rdy2", {31'b0, jump_base_rdy_from_rf_0}, 32'd0);

    // Flush in RESP gates the pulse; last_wait keeps its previous value.
    jmp_req_valid = 1'b1; jmp_req_rs = 4'd3;
    cyc();
    jmp_req_valid = 1'b0;
    cyc();
    has_mispredict = 1'b1;
    #1;
    check_eq("fr_rdy", {31'b0, jump_base_rdy_from_rf_0}, 32'd0);
    cyc();
    has_mispredict = 1'b0;
    #1;
    check_eq("fr_ready", {31'b0, jmp_req_ready}, 32'd1);
    check_eq("fr_rdy2", {31'b0, jump_base_rdy_from_rf_0}, 32'd0);
`ifdef JB_WB_BYPASS_EN
    check_eq("fr_last", {24'b0, last_wait_cycles}, 32'd0);
`else
    check_eq("fr_last", {24'b0, last_wait_cycles}, 32'd4);
`endif

    // Request together with flush in IDLE is dropped.
    jmp_req_valid = 1'b1; jmp_req_rs = 4'd2; has_mispredict = 1'b1;
    cyc();
    jmp_req_valid = 1'b0; has_mispredict = 1'b0;
    #1;
    check_eq("fi_ready", {31'b0, jmp_req_ready}, 32'd1);
    cyc();
    check_eq("fi_rdy", {31'b0, jump_base_rdy_from_rf_0}, 32'd0);

    // Normal request after the flushes.
    run_req(4'd2, 0, 16'h0, 1'b0, 16'h0, lat, base);
    check_eq("post_lat", 32'(lat), 32'd2);
    check_eq("post_base", {16'b0, base}, 32'h2222);
    after_resp("post", 8'd0);

    // Register 0 with every busy bit set.
    run_req(4'd0, 1000, 16'hFFFF, 1'b0, 16'h0, lat, base);
    check_eq("r0_lat", 32'(lat), 32'd2);
    check_eq("r0_base", {16'b0, base}, 32'h0000);
    after_resp("r0", 8'd0);

    // 300 busy cycles saturates the wait counter.
    run_req(4'd7, 300, 16'h0080, 1'b0, 16'h0, lat, base);
    check_eq("sat_lat", 32'(lat), 32'd302);
    check_eq("sat_base", {16'b0, base}, 32'h7777);
    after_resp("sat", 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
